instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers words in a circular FIFO and drains them to the
// CPU as registered one-cycle issue pulses spaced GAP+1 cycles apart.
module instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 5
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     loadInstr,
  input  logic [31:0]              loadWord,
  input  logic                     start,
  input  logic                     abort,
  output logic [31:0]              instrWord,
  output logic                     newInstr,
  output logic                     busy,
  output logic                     done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      gap_q, gap_d;
  logic [31:0]     instr_q, instr_d;
  logic            new_q, new_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     mem [DEPTH];

  logic            full_w;
  logic            pop;
  logic            push;

  assign full_w = (count_q == FULL_CNT);
  // A pop on the same edge frees a slot, so a load while full is still accepted.
  assign pop    = (state_q == ISSUE) && !abort;
  assign push   = loadInstr && !abort && (!full_w || pop);

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    new_d    = 1'b0;
    done_d   = 1'b0;
    instr_d  = instr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start && (count_q != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        gap_d   = GAP_LOAD;
        new_d   = 1'b1;
        busy_d  = 1'b1;
        instr_d = mem[rd_ptr_q];
      end
      WAIT: begin
        if (gap_q == 8'd0) begin
          if (count_q != '0) begin
            state_d = ISSUE;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (loadInstr && full_w && !pop) ovf_d = 1'b1;

    // Abort flushes everything except the last issued word.
    if (abort) begin
      state_d  = IDLE;
      new_d    = 1'b0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      instr_d  = instr_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      gap_q    <= 8'd0;
      busy_q   <= 1'b0;
      new_q    <= 1'b0;
      done_q   <= 1'b0;
      instr_q  <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      new_q    <= new_d;
      done_q   <= done_d;
      instr_q  <= instr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge Clk) begin
    if (Reset && push) mem[wr_ptr_q] <= loadWord;
  end

  assign instrWord = instr_q;
  assign newInstr  = new_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign full      = full_w;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (DEPTH=8, GAP=5): issue pulses and done
// pulses are logged on the falling edge and compared against hand-computed values.
module tb_instr_sequencer;

  logic        Clk;
  logic        Reset;
  logic        loadInstr;
  logic [31:0] loadWord;
  logic        start;
  logic        abort;
  logic [31:0] instrWord;
  logic        newInstr;
  logic        busy;
  logic        done;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;

  instr_sequencer #(.DEPTH(8), .GAP(5)) dut (
    .Clk(Clk), .Reset(Reset), .loadInstr(loadInstr), .loadWord(loadWord),
    .start(start), .abort(abort), .instrWord(instrWord), .newInstr(newInstr),
    .busy(busy), .done(done), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          cyc = 0;
  logic [31:0] pw[$];
  int          pc[$];
  int          ndone = 0;
  int          done_cyc = -1;
  int          done_count = -1;
  int          errs = 0;
  int          checks = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (newInstr === 1'b1) begin
      pw.push_back(instrWord);
      pc.push_back(cyc);
    end
    if (done === 1'b1) begin
      ndone = ndone + 1;
      done_cyc = cyc;
      done_count = int'(count);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] w);
    loadInstr = 1'b1;
    loadWord  = w;
    tick();
    loadInstr = 1'b0;
  endtask

  task automatic clr_log();
    pw.delete();
    pc.delete();
    ndone = 0;
    done_cyc = -1;
    done_count = -1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  function automatic logic [31:0] pw_at(input int i);
    if (i < pw.size()) return pw[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int pc_at(input int i);
    if (i < pc.size()) return pc[i];
    return -1;
  endfunction

  logic [31:0] prog [6] = '{32'h8C010000, 32'h8C020001, 32'h8C030002,
                            32'h00222020, 32'h00832022, 32'hAC040003};
  int s;

  initial begin
    Reset = 1'b0; loadInstr = 1'b0; loadWord = 32'h0; start = 1'b0; abort = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_new", 32'(newInstr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word", instrWord, 32'h0);
    Reset = 1'b1;
    tick();

    // Six-word program drained in load order.
    clr_log();
    for (int i = 0; i < 6; i++) load(prog[i]);
    chk("prog_count", 32'(count), 32'd6);
    pulse_start(s);
    chk("prog_busy_issue", 32'(busy), 32'd0);
    tick();
    chk("prog_first_new", 32'(newInstr), 32'd1);
    chk("prog_first_word", instrWord, 32'h8C010000);
    chk("prog_first_busy", 32'(busy), 32'd1);
    repeat (44) tick();
    chk("prog_npulse", 32'(pw.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("prog_word%0d", i), pw_at(i), prog[i]);
      chk($sformatf("prog_cyc%0d", i), 32'(pc_at(i)), 32'(s + 1 + 6 * i));
    end
    chk("prog_ndone", 32'(ndone), 32'd1);
    chk("prog_done_cyc", 32'(done_cyc), 32'(s + 37));
    chk("prog_empty", 32'(empty), 32'd1);
    chk("prog_busy_end", 32'(busy), 32'd0);
    chk("prog_word_hold", instrWord, 32'hAC040003);

    // Nine loads into an 8-deep buffer.
    clr_log();
    for (int i = 0; i < 8; i++) load(32'h1000_0000 + 32'(i));
    chk("ovf_full8", 32'(full), 32'd1);
    chk("ovf_count8", 32'(count), 32'd8);
    chk("ovf_flag8", 32'(overflow), 32'd0);
    load(32'h1000_0008);
    chk("ovf_flag9", 32'(overflow), 32'd1);
    chk("ovf_count9", 32'(count), 32'd8);
    chk("ovf_word_unchanged", instrWord, 32'hAC040003);
    pulse_start(s);
    repeat (55) tick();
    chk("ovf_npulse", 32'(pw.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("ovf_word%0d", i), pw_at(i), 32'h1000_0000 + 32'(i));
    chk("ovf_ndone", 32'(ndone), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    pulse_abort();
    chk("ovf_abort_clr", 32'(overflow), 32'd0);

    // Word loaded during the first WAIT joins the same run.
    clr_log();
    load(32'h2000_0000);
    load(32'h2000_0001);
    pulse_start(s);
    tick();
    load(32'h2000_0002);
    repeat (30) tick();
    chk("mid_npulse", 32'(pw.size()), 32'd3);
    chk("mid_word2", pw_at(2), 32'h2000_0002);
    chk("mid_cyc2", 32'(pc_at(2)), 32'(s + 13));
    chk("mid_ndone", 32'(ndone), 32'd1);
    chk("mid_done_count", 32'(done_count), 32'd0);

    // Abort one cycle after the second pulse.
    clr_log();
    for (int i = 0; i < 4; i++) load(32'h3000_0000 + 32'(i));
    pulse_start(s);
    repeat (8) tick();
    pulse_abort();
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_new", 32'(newInstr), 32'd0);
    repeat (30) tick();
    chk("abort_npulse", 32'(pw.size()), 32'd2);
    chk("abort_ndone", 32'(ndone), 32'd0);

    // Abort while in ISSUE cancels that pulse; the same-edge load is dropped.
    clr_log();
    load(32'h3100_0000);
    pulse_start(s);
    loadInstr = 1'b1;
    loadWord  = 32'h3100_0001;
    pulse_abort();
    loadInstr = 1'b0;
    chk("abort_iss_new", 32'(newInstr), 32'd0);
    chk("abort_iss_count", 32'(count), 32'd0);
    repeat (10) tick();
    chk("abort_iss_npulse", 32'(pw.size()), 32'd0);

    // Start on an empty buffer is ignored; reset then cuts a run short.
    clr_log();
    pulse_start(s);
    repeat (10) tick();
    chk("empty_npulse", 32'(pw.size()), 32'd0);
    chk("empty_ndone", 32'(ndone), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) load(32'h4000_0000 + 32'(i));
    pulse_start(s);
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_new", 32'(newInstr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_word", instrWord, 32'h0);
    Reset = 1'b1;
    repeat (20) tick();
    chk("mrst_npulse", 32'(pw.size()), 32'd1);
    chk("mrst_ndone", 32'(ndone), 32'd0);

    // Load on every ISSUE edge with the buffer full, across three buffer wraps.
    clr_log();
    for (int i = 0; i < 8; i++) load(32'h5000_0000 + 32'(i));
    pulse_start(s);
    for (int k = 0; k < 24; k++) begin
      load(32'h5000_0008 + 32'(k));
      chk($sformatf("wrap_count%0d", k), 32'(count), 32'd8);
      repeat (5) tick();
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_npulse", 32'(pw.size()), 32'd24);
    for (int i = 0; i < 24; i++)
      chk($sformatf("wrap_word%0d", i), pw_at(i), 32'h5000_0000 + 32'(i));
    pulse_abort();
    chk("wrap_abort_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
